// File: rtl/lcd_cmd_sequencer_pkg.sv
// Shared types, display command opcodes and object colour lookup for the
// LCD command sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT_CMD,
    INIT_WAIT,
    FILL_CMD,
    PIXEL,
    DONE
  } state_t;

  localparam logic [7:0] CMD_RESET     = 8'h01;
  localparam logic [7:0] CMD_DISP_OFF  = 8'h28;
  localparam logic [7:0] CMD_SLEEP_OUT = 8'h11;
  localparam logic [7:0] CMD_DISP_ON   = 8'h29;
  localparam logic [7:0] CMD_CASET     = 8'h2A;
  localparam logic [7:0] CMD_PASET     = 8'h2B;
  localparam logic [7:0] CMD_RAMWR     = 8'h2C;

  // RGB565 fill colour per board object; unused codes paint white
  function automatic logic [15:0] obj_colour(input logic [2:0] obj);
    case (obj)
      3'd1:    return 16'h901E;
      3'd2:    return 16'h6815;
      3'd3:    return 16'hF800;
      3'd4:    return 16'h0814;
      default: return 16'hFFFF;
    endcase
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Request and byte-link handshake bundle between a host and the sequencer.
interface lcd_cmd_sequencer_if #(
  parameter int COORD_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic               req_kind;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic [2:0]         req_obj;
  logic [7:0]         d;
  logic               dcx;
  logic               wr_valid;
  logic               wr_ready;

  modport master (
    output req_valid, req_kind, req_x, req_y, req_obj, wr_ready,
    input  req_ready, d, dcx, wr_valid
  );

  modport slave (
    input  req_valid, req_kind, req_x, req_y, req_obj, wr_ready,
    output req_ready, d, dcx, wr_valid
  );
endinterface

// File: rtl/lcd_cmd_sequencer_delay_timer.sv
// Down-counter that times the post-command waits; expired is high once the
// loaded count has run out.
module lcd_delay_timer #(
  parameter int DELAY_CYC = 50000
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  output logic expired
);

  localparam int               CNT_W = $clog2(DELAY_CYC) + 1;
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DELAY_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      count <= '0;
    else if (start)
      count <= LOAD;
    else if (count != '0)
      count <= count - CNT_W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Emits the display init sequence or a filled cell (window set + RAM write)
// as a stream of command/data bytes over a valid/ready byte link.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CELL_PX   = 20,
  parameter int COORD_W   = 4,
  parameter int DELAY_CYC = 50000
) (
  input  logic                clk,
  input  logic                nrst,
  lcd_cmd_sequencer_if.slave  bus,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0] PIX_TOTAL = 16'(CELL_PX * CELL_PX);

  state_t             state;
  logic               kind_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [2:0]         obj_q;
  logic [3:0]         idx;
  logic [15:0]        pix_cnt;
  logic               pix_lo;
  logic [7:0]         d_q;
  logic               dcx_q;
  logic               wr_valid_q;

  logic        take;
  logic        timer_start;
  logic        timer_expired;
  logic [3:0]  nidx;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] colour;
  logic [7:0]  fill_byte;
  logic        fill_dcx;

  assign take          = wr_valid_q && bus.wr_ready;
  assign timer_start   = take && (state == INIT_CMD) && !kind_q && !idx[0];
  assign nidx          = idx + 4'd1;
  assign sc            = 16'(x_q) * 16'(CELL_PX);
  assign ec            = sc + 16'(CELL_PX - 1);
  assign sp            = 16'(y_q) * 16'(CELL_PX);
  assign ep            = sp + 16'(CELL_PX - 1);
  assign colour        = obj_colour(obj_q);

  assign bus.req_ready = (state == IDLE);
  assign bus.d         = d_q;
  assign bus.dcx       = dcx_q;
  assign bus.wr_valid  = wr_valid_q;
  assign busy          = (state != IDLE);

  lcd_delay_timer #(
    .DELAY_CYC (DELAY_CYC)
  ) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .start   (timer_start),
    .expired (timer_expired)
  );

  // Header byte that follows header index idx; opcodes sit at 0, 5 and 10
  always_comb begin
    fill_byte = CMD_CASET;
    case (nidx)
      4'd1:    fill_byte = sc[15:8];
      4'd2:    fill_byte = sc[7:0];
      4'd3:    fill_byte = ec[15:8];
      4'd4:    fill_byte = ec[7:0];
      4'd5:    fill_byte = CMD_PASET;
      4'd6:    fill_byte = sp[15:8];
      4'd7:    fill_byte = sp[7:0];
      4'd8:    fill_byte = ep[15:8];
      4'd9:    fill_byte = ep[7:0];
      4'd10:   fill_byte = CMD_RAMWR;
      default: fill_byte = CMD_CASET;
    endcase
    fill_dcx = !(nidx == 4'd5 || nidx == 4'd10);
  end

  // A new byte is loaded only on an accepted transfer, so d/dcx hold during stalls
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      kind_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      obj_q      <= '0;
      idx        <= '0;
      pix_cnt    <= '0;
      pix_lo     <= 1'b0;
      d_q        <= '0;
      dcx_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            kind_q     <= bus.req_kind;
            x_q        <= bus.req_x;
            y_q        <= bus.req_y;
            obj_q      <= bus.req_obj;
            idx        <= '0;
            dcx_q      <= 1'b0;
            wr_valid_q <= 1'b1;
            if (bus.req_kind) begin
              d_q   <= CMD_CASET;
              state <= FILL_CMD;
            end else begin
              d_q   <= CMD_RESET;
              state <= INIT_CMD;
            end
          end
        end
        INIT_CMD: begin
          if (take) begin
            idx <= nidx;
            if (idx == 4'd3) begin
              wr_valid_q <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (!idx[0]) begin
              wr_valid_q <= 1'b0;
              state      <= INIT_WAIT;
            end else begin
              d_q <= CMD_SLEEP_OUT;
            end
          end
        end
        INIT_WAIT: begin
          if (timer_expired) begin
            d_q        <= (idx == 4'd1) ? CMD_DISP_OFF : CMD_DISP_ON;
            wr_valid_q <= 1'b1;
            state      <= INIT_CMD;
          end
        end
        FILL_CMD: begin
          if (take) begin
            if (idx == 4'd10) begin
              d_q     <= colour[15:8];
              dcx_q   <= 1'b1;
              pix_cnt <= PIX_TOTAL;
              pix_lo  <= 1'b0;
              idx     <= '0;
              state   <= PIXEL;
            end else begin
              d_q   <= fill_byte;
              dcx_q <= fill_dcx;
              idx   <= nidx;
            end
          end
        end
        PIXEL: begin
          if (take) begin
            if (!pix_lo) begin
              d_q    <= colour[7:0];
              pix_lo <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt - 16'd1;
              pix_lo  <= 1'b0;
              if (pix_cnt == 16'd1) begin
                wr_valid_q <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end else begin
                d_q <= colour[15:8];
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed self-checking bench for lcd_cmd_sequencer: init timing, cell fills,
// backpressure, reset abort and request holding.
module tb_lcd_cmd_sequencer;

  localparam int CELL_PX   = 20;
  localparam int COORD_W   = 4;
  localparam int DELAY_CYC = 8;
  localparam int FILL_LEN  = 11 + 2 * CELL_PX * CELL_PX;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic busy;
  logic done;

  lcd_cmd_sequencer_if #(.COORD_W(COORD_W)) bus ();

  lcd_cmd_sequencer #(
    .CELL_PX   (CELL_PX),
    .COORD_W   (COORD_W),
    .DELAY_CYC (DELAY_CYC)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int         checks     = 0;
  int         failures   = 0;
  int         cyc        = 0;
  int         done_cnt   = 0;
  int         done_cyc   = 0;
  int         acc_cnt    = 0;
  int         acc_cyc    = 0;
  logic [8:0] bytes_q[$];
  int         tcyc_q[$];
  logic [8:0] ref_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte  = '0;
  bit         rand_mode  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Link monitor: records accepted bytes, accepted requests and done pulses
  always @(negedge clk) begin
    cyc++;
    if (nrst && bus.req_valid && bus.req_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (nrst && bus.wr_valid && prev_stall)
      checkOutput("stall_hold", 32'({bus.dcx, bus.d}), 32'(prev_byte));
    prev_stall = nrst && bus.wr_valid && !bus.wr_ready;
    prev_byte  = {bus.dcx, bus.d};
    if (nrst && bus.wr_valid && bus.wr_ready) begin
      bytes_q.push_back({bus.dcx, bus.d});
      tcyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.wr_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clearCapture();
    bytes_q.delete();
    tcyc_q.delete();
  endtask

  task automatic applyStimulus(input logic kind, input logic [3:0] x, input logic [3:0] y,
                               input logic [2:0] obj, input bit hold);
    int a0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_kind  = kind;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_obj   = obj;
    a0 = acc_cnt;
    for (int i = 0; i < 3000 && acc_cnt == a0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("req_accepted", 32'(acc_cnt - a0), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    checkOutput(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic checkFill(input string tag, input logic [10:0][7:0] hdr,
                           input logic [7:0] hi, input logic [7:0] lo);
    int bad;
    checkOutput({tag, "_count"}, 32'(bytes_q.size()), 32'(FILL_LEN));
    for (int i = 0; i < 11; i++)
      checkOutput($sformatf("%s_hdr%0d", tag, i),
                  (i < bytes_q.size()) ? 32'(bytes_q[i]) : 32'hDEAD,
                  32'({(i != 0 && i != 5 && i != 10), hdr[10-i]}));
    bad = 0;
    for (int i = 11; i < bytes_q.size(); i++)
      if (bytes_q[i] !== {1'b1, (((i - 11) % 2) == 0) ? hi : lo}) bad++;
    checkOutput({tag, "_pixel_errs"}, 32'(bad), 32'd0);
    if (tcyc_q.size() > 0)
      checkOutput({tag, "_done_lat"}, 32'(done_cyc - tcyc_q[$]), 32'd1);
  endtask

  initial begin
    int d_start;
    int a_start;
    int held;
    int bad;
    bus.req_valid = 1'b0;
    bus.req_kind  = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_obj   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_d", 32'(bus.d), 32'd0);
    checkOutput("rst_dcx", 32'(bus.dcx), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Init sequence with DELAY_CYC=8
    $display("[TB] init sequence");
    clearCapture();
    d_start = done_cnt;
    applyStimulus(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    waitDone(300, "init_done");
    checkOutput("init_count", 32'(bytes_q.size()), 32'd4);
    if (bytes_q.size() == 4) begin
      checkOutput("init_b0", 32'(bytes_q[0]), 32'h001);
      checkOutput("init_b1", 32'(bytes_q[1]), 32'h028);
      checkOutput("init_b2", 32'(bytes_q[2]), 32'h011);
      checkOutput("init_b3", 32'(bytes_q[3]), 32'h029);
      checkOutput("init_first_lat", 32'(tcyc_q[0] - acc_cyc), 32'd1);
      checkOutput("init_gap0", 32'(tcyc_q[1] - tcyc_q[0]), 32'(DELAY_CYC + 1));
      checkOutput("init_gap1", 32'(tcyc_q[2] - tcyc_q[1]), 32'd1);
      checkOutput("init_gap2", 32'(tcyc_q[3] - tcyc_q[2]), 32'(DELAY_CYC + 1));
      checkOutput("init_done_lat", 32'(done_cyc - tcyc_q[3]), 32'd1);
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("init_done_pulses", 32'(done_cnt - d_start), 32'd1);
    checkOutput("init_busy_after", 32'(busy), 32'd0);

    // Cell fill x=3 y=2 obj=3
    $display("[TB] fill x=3 y=2 obj=3");
    clearCapture();
    applyStimulus(1'b1, 4'd3, 4'd2, 3'd3, 1'b0);
    waitDone(2000, "fill_done");
    checkFill("fill", {8'h2A, 8'h00, 8'h3C, 8'h00, 8'h4F, 8'h2B,
                       8'h00, 8'h28, 8'h00, 8'h3B, 8'h2C}, 8'hF8, 8'h00);
    if (tcyc_q.size() > 0)
      checkOutput("fill_first_lat", 32'(tcyc_q[0] - acc_cyc), 32'd1);
    ref_q = bytes_q;

    // Same fill under random backpressure
    $display("[TB] fill with random wr_ready");
    clearCapture();
    rand_mode = 1'b1;
    applyStimulus(1'b1, 4'd3, 4'd2, 3'd3, 1'b0);
    waitDone(6000, "bp_done");
    rand_mode = 1'b0;
    checkOutput("bp_count", 32'(bytes_q.size()), 32'(ref_q.size()));
    bad = 0;
    for (int i = 0; i < bytes_q.size() && i < ref_q.size(); i++)
      if (bytes_q[i] !== ref_q[i]) bad++;
    checkOutput("bp_byte_errs", 32'(bad), 32'd0);

    // Upper corner cell
    $display("[TB] fill x=15 y=15 obj=1");
    clearCapture();
    applyStimulus(1'b1, 4'd15, 4'd15, 3'd1, 1'b0);
    waitDone(2000, "corner_done");
    checkFill("corner", {8'h2A, 8'h01, 8'h2C, 8'h01, 8'h3F, 8'h2B,
                         8'h01, 8'h2C, 8'h01, 8'h3F, 8'h2C}, 8'h90, 8'h1E);

    // Reset in the middle of the pixel stream
    $display("[TB] reset mid-pixel");
    clearCapture();
    applyStimulus(1'b1, 4'd5, 4'd5, 3'd2, 1'b0);
    for (int i = 0; i < 500 && bytes_q.size() < 60; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("mid_reached", 32'(bytes_q.size() >= 60), 32'd1);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    held = bytes_q.size();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    checkOutput("mid_rst_no_bytes", 32'(bytes_q.size()), 32'(held));
    clearCapture();
    applyStimulus(1'b1, 4'd0, 4'd0, 3'd0, 1'b0);
    waitDone(2000, "restart_done");
    checkFill("restart", {8'h2A, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2B,
                          8'h00, 8'h00, 8'h00, 8'h13, 8'h2C}, 8'hFF, 8'hFF);

    // req_valid held high while busy; obj=6 paints white
    $display("[TB] held request obj=6");
    clearCapture();
    a_start = acc_cnt;
    applyStimulus(1'b1, 4'd1, 4'd0, 3'd6, 1'b1);
    checkOutput("held_busy_ready", 32'(bus.req_ready), 32'd0);
    waitDone(2000, "held_done");
    checkOutput("held_single_accept", 32'(acc_cnt - a_start), 32'd1);
    checkOutput("held_done_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    checkFill("held", {8'h2A, 8'h00, 8'h14, 8'h00, 8'h27, 8'h2B,
                       8'h00, 8'h00, 8'h00, 8'h13, 8'h2C}, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("held_idle_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
